// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Definitions shared by the data-memory path: the SRAM controller state
// encoding, the default byte address of data word 0 and the word-index helper.
// No ports (package).
// -----------------------------------------------------------------------------
package arm_pkg;

    // Access sequencer states: a 32-bit access is two 16-bit SRAM halves.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;
    localparam int unsigned IDX_W             = 17;

    // Word index inside data memory. Addresses below the base wrap modulo 2^32
    // and are deliberately not flagged; the result is truncated to IDX_W bits.
    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] base);
        return IDX_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// 4-bit cycle counter used to time each SRAM half access.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset (count -> 0)
//   clr_i  - synchronous clear, has priority over enable
//   en_i   - count enable
//   tc_o   - terminal count: high while count == LIMIT-1
// -----------------------------------------------------------------------------
module wait_counter #(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [3:0] TC_VAL = 4'(LIMIT - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Bridges the 32-bit MEM-stage load/store port to a 16-bit asynchronous SRAM.
// Each access is split into a low half (LO) and a high half (HI), each held
// for WAIT_CYCLES cycles, followed by one DONE cycle in which ready is high.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   wr_en, rd_en    - store / load request (both high = store)
//   address         - byte address from the ALU
//   write_data      - store data
//   read_data       - registered load result
//   ready           - access complete or idle; pipeline stalls while low
//   sram_addr       - SRAM half-word address
//   sram_we_n       - SRAM write strobe, active-low
//   sram_dq_out     - data driven toward the SRAM
//   sram_dq_oe      - high when the controller drives the DQ bus
//   sram_dq_in      - data returned from the SRAM
// The bidirectional DQ pad is built one level up from sram_dq_out/_oe/_in.
// -----------------------------------------------------------------------------
module sram_controller
    import arm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    sram_state_e      state_q, state_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;

    logic req;
    logic tc;
    logic cnt_clr;

    assign req = rd_en | wr_en;

    // The counter only runs inside LO/HI; it restarts at each phase boundary.
    assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_DONE) || tc;

    wait_counter #(
        .LIMIT (WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (1'b1),
        .tc_o  (tc)
    );

    // Next state, latched access and read capture.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LO;
                    op_wr_d = wr_en;
                    idx_d   = word_index(address, DATA_BASE);
                    wdata_d = write_data;
                end
            end
            ST_LO: begin
                if (tc) begin
                    state_d = ST_HI;
                    if (!op_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end
            end
            ST_HI: begin
                if (tc) begin
                    state_d = ST_DONE;
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM pins are decoded from registered state so reset clears them
    // immediately and they are glitch-free relative to the request inputs.
    always_comb begin
        sram_addr   = 18'd0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'd0;
        case (state_q)
            ST_LO: begin
                sram_addr = {idx_q, 1'b0};
                if (op_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end
            end
            ST_HI: begin
                sram_addr = {idx_q, 1'b1};
                if (op_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end
            end
            default: begin
            end
        endcase
    end

    assign ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance 0: WAIT_CYCLES = 2
    logic        wr0, rd0;
    logic [31:0] addr0, wdat0, rdata0;
    logic        ready0, we_n0, oe0;
    logic [17:0] saddr0;
    logic [15:0] dqo0, dqi0;

    // Instance 1: WAIT_CYCLES = 1
    logic        wr1, rd1;
    logic [31:0] addr1, wdat1, rdata1;
    logic        ready1, we_n1, oe1;
    logic [17:0] saddr1;
    logic [15:0] dqo1, dqi1;
    logic [15:0] lo1, hi1;

    logic [15:0] mem0 [0:7];

    int checks   = 0;
    int failures = 0;

    sram_controller #(.WAIT_CYCLES(2), .DATA_BASE(32'd1024)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
        .write_data(wdat0), .read_data(rdata0), .ready(ready0),
        .sram_addr(saddr0), .sram_we_n(we_n0), .sram_dq_out(dqo0),
        .sram_dq_oe(oe0), .sram_dq_in(dqi0)
    );

    sram_controller #(.WAIT_CYCLES(1), .DATA_BASE(32'd1024)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wdat1), .read_data(rdata1), .ready(ready1),
        .sram_addr(saddr1), .sram_we_n(we_n1), .sram_dq_out(dqo1),
        .sram_dq_oe(oe1), .sram_dq_in(dqi1)
    );

    // Simple asynchronous SRAM for instance 0 (8 half-words).
    assign dqi0 = mem0[saddr0[2:0]];
    always @(posedge clk) begin
        if (!we_n0 && oe0) mem0[saddr0[2:0]] <= dqo0;
    end

    // Instance 1 SRAM returns lo1 on even half addresses, hi1 on odd.
    assign dqi1 = saddr1[0] ? hi1 : lo1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem0[i] = 16'h0000;
        mem0[6] = 16'h1111;
        mem0[7] = 16'h2222;
        rst = 1'b1;
        wr0 = 1'b0; rd0 = 1'b0; addr0 = 32'd0; wdat0 = 32'd0;
        wr1 = 1'b0; rd1 = 1'b0; addr1 = 32'd0; wdat1 = 32'd0;
        lo1 = 16'h1234; hi1 = 16'h5678;
        #1;
        chk("rst_read_data", rdata0, 32'd0);
        chk("rst_sram_addr", 32'(saddr0), 32'd0);
        chk("rst_we_n", 32'(we_n0), 32'd1);
        chk("rst_dq_oe", 32'(oe0), 32'd0);
        chk("rst_dq_out", 32'(dqo0), 32'd0);
        chk("rst_ready", 32'(ready0), 32'd1);

        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_ready", 32'(ready0), 32'd1);

        // Write 32'hDEADBEEF to 1028; request dropped after cycle 0.
        @(negedge clk); wr0 = 1'b1; addr0 = 32'd1028; wdat0 = 32'hDEADBEEF; #1;
        chk("wr_c0_ready", 32'(ready0), 32'd0);
        @(negedge clk); wr0 = 1'b0; addr0 = 32'd0; wdat0 = 32'd0; #1;
        chk("wr_c1_addr", 32'(saddr0), 32'd2);
        chk("wr_c1_dq", 32'(dqo0), 32'h0000BEEF);
        chk("wr_c1_we_n", 32'(we_n0), 32'd0);
        chk("wr_c1_oe", 32'(oe0), 32'd1);
        chk("wr_c1_ready", 32'(ready0), 32'd0);
        @(negedge clk); #1;
        chk("wr_c2_addr", 32'(saddr0), 32'd2);
        chk("wr_c2_dq", 32'(dqo0), 32'h0000BEEF);
        @(negedge clk); #1;
        chk("wr_c3_addr", 32'(saddr0), 32'd3);
        chk("wr_c3_dq", 32'(dqo0), 32'h0000DEAD);
        chk("wr_c3_we_n", 32'(we_n0), 32'd0);
        @(negedge clk); #1;
        chk("wr_c4_addr", 32'(saddr0), 32'd3);
        chk("wr_c4_dq", 32'(dqo0), 32'h0000DEAD);
        chk("wr_c4_ready", 32'(ready0), 32'd0);
        @(negedge clk); #1;
        chk("wr_c5_ready", 32'(ready0), 32'd1);
        chk("wr_c5_we_n", 32'(we_n0), 32'd1);
        chk("wr_c5_addr", 32'(saddr0), 32'd0);
        @(negedge clk); #1;
        chk("wr_idle_ready", 32'(ready0), 32'd1);

        // Read back 1028.
        @(negedge clk); rd0 = 1'b1; addr0 = 32'd1028; #1;
        chk("rd_c0_ready", 32'(ready0), 32'd0);
        @(negedge clk); rd0 = 1'b0; #1;
        chk("rd_c1_addr", 32'(saddr0), 32'd2);
        chk("rd_c1_oe", 32'(oe0), 32'd0);
        chk("rd_c1_we_n", 32'(we_n0), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rd_c3_addr", 32'(saddr0), 32'd3);
        chk("rd_c3_low_half", rdata0, 32'h0000BEEF);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rd_c5_ready", 32'(ready0), 32'd1);
        chk("rd_c5_data", rdata0, 32'hDEADBEEF);

        // Write 32'h12345678 to 1032; read_data must hold.
        @(negedge clk); wr0 = 1'b1; addr0 = 32'd1032; wdat0 = 32'h12345678; #1;
        @(negedge clk); wr0 = 1'b0; #1;
        chk("wr2_c1_addr", 32'(saddr0), 32'd4);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("wr2_c5_ready", 32'(ready0), 32'd1);
        chk("wr2_hold_rdata", rdata0, 32'hDEADBEEF);
        chk("wr2_mem_lo", 32'(mem0[4]), 32'h00005678);
        chk("wr2_mem_hi", 32'(mem0[5]), 32'h00001234);

        // Both rd_en and wr_en high -> store to 1036.
        @(negedge clk); wr0 = 1'b1; rd0 = 1'b1; addr0 = 32'd1036; wdat0 = 32'hCAFEF00D; #1;
        @(negedge clk); wr0 = 1'b0; rd0 = 1'b0; #1;
        chk("both_c1_addr", 32'(saddr0), 32'd6);
        chk("both_c1_we_n", 32'(we_n0), 32'd0);
        chk("both_c1_oe", 32'(oe0), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("both_c5_ready", 32'(ready0), 32'd1);
        chk("both_rdata", rdata0, 32'hDEADBEEF);
        chk("both_mem_lo", 32'(mem0[6]), 32'h0000F00D);
        chk("both_mem_hi", 32'(mem0[7]), 32'h0000CAFE);

        // Reset in the middle of the HI phase of a write to 1028.
        @(negedge clk); wr0 = 1'b1; addr0 = 32'd1028; wdat0 = 32'h0BADF00D; #1;
        @(negedge clk); wr0 = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rstmid_hi_we_n", 32'(we_n0), 32'd0);
        chk("rstmid_hi_addr", 32'(saddr0), 32'd3);
        rst = 1'b1; #1;
        chk("rstmid_we_n", 32'(we_n0), 32'd1);
        chk("rstmid_oe", 32'(oe0), 32'd0);
        chk("rstmid_addr", 32'(saddr0), 32'd0);
        chk("rstmid_dq_out", 32'(dqo0), 32'd0);
        chk("rstmid_rdata", rdata0, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rstmid_next_ready", 32'(ready0), 32'd1);
        chk("rstmid_next_we_n", 32'(we_n0), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rstmid_no_retry_we_n", 32'(we_n0), 32'd1);
        chk("rstmid_no_retry_ready", 32'(ready0), 32'd1);
        chk("rstmid_hi_untouched", 32'(mem0[3]), 32'h0000DEAD);

        // Instance 1: back-to-back reads of 1020 (index wraps to 17'h1FFFF).
        @(negedge clk); rd1 = 1'b1; addr1 = 32'd1020; #1;
        chk("b2b_c0_ready", 32'(ready1), 32'd0);
        @(negedge clk); #1;
        chk("b2b_c1_addr", 32'(saddr1), 32'h3FFFE);
        chk("b2b_c1_ready", 32'(ready1), 32'd0);
        @(negedge clk); #1;
        chk("b2b_c2_addr", 32'(saddr1), 32'h3FFFF);
        @(negedge clk); #1;
        chk("b2b_c3_ready", 32'(ready1), 32'd1);
        chk("b2b_c3_data", rdata1, 32'h56781234);
        @(negedge clk); lo1 = 16'hAAAA; hi1 = 16'h5555; #1;
        chk("b2b_c4_ready", 32'(ready1), 32'd0);
        chk("b2b_c4_addr", 32'(saddr1), 32'd0);
        @(negedge clk); #1;
        chk("b2b_c5_addr", 32'(saddr1), 32'h3FFFE);
        chk("b2b_c5_ready", 32'(ready1), 32'd0);
        @(negedge clk); #1;
        chk("b2b_c6_ready", 32'(ready1), 32'd0);
        @(negedge clk); #1;
        chk("b2b_c7_ready", 32'(ready1), 32'd1);
        chk("b2b_c7_data", rdata1, 32'h5555AAAA);
        @(negedge clk); rd1 = 1'b0; #1;
        chk("b2b_idle_ready", 32'(ready1), 32'd1);
        chk("b2b_we_n", 32'(we_n1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM cycles held per 16-bit half access; legal range 1..15.
REQ-002 Parameter DATA_BASE, default 32'd1024, byte address of data memory word 0.
REQ-003 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr_en  input  1  MEM-stage store request (STR).
REQ-006 rd_en  input  1  MEM-stage load request (LDR).
REQ-007 address  input  32  byte address from the ALU result.
REQ-008 write_data  input  32  store data (Rm value).
REQ-009 read_data  output  32  load result, registered.
REQ-010 ready  output  1  access complete or idle; pipeline freezes while low.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-013 sram_dq_out  output  16  data driven to SRAM.
REQ-014 sram_dq_oe  output  1  high = controller drives the DQ bus.
REQ-015 sram_dq_in  input  16  data returned from SRAM.

Function
REQ-016 States SHALL be IDLE, LO, HI and DONE, with a 4-bit wait counter.
REQ-017 A request is rd_en|wr_en; if both are high, it SHALL be treated as a write.
REQ-018 IDLE SHALL move to LO on a request, latching the operation, word index and write_data; the counter clears.
REQ-019 LO and HI SHALL each last exactly WAIT_CYCLES cycles; the counter reaching WAIT_CYCLES-1 advances LO->HI and HI->DONE.
REQ-020 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-021 Word index = (address - DATA_BASE) >> 2, computed modulo 2^32 and truncated to 17 bits; addresses below DATA_BASE wrap and are not flagged.
REQ-022 sram_addr SHALL be {index,1'b0} in LO, {index,1'b1} in HI and 0 otherwise.
REQ-023 On writes, LO SHALL drive write_data[15:0] and HI SHALL drive write_data[31:16], with sram_dq_oe=1 and sram_we_n=0 for all cycles of both phases.
REQ-024 On reads, sram_dq_oe SHALL be 0 and sram_we_n 1; sram_dq_in is captured into read_data[15:0] on the last LO cycle and into read_data[31:16] on the last HI cycle.
REQ-025 read_data SHALL hold its value until the next read overwrites it; writes SHALL leave it unchanged.
REQ-026 ready = (state==DONE) | (state==IDLE & no request); this is combinational from state, rd_en and wr_en.
REQ-027 Request-to-ready latency SHALL be 2*WAIT_CYCLES+1 cycles, counting the request cycle as cycle 0.
REQ-028 Requests that drop or change mid-access SHALL be ignored; the latched access runs to DONE.
REQ-029 A request present in the cycle after DONE (IDLE) SHALL start a new access with no idle gap.

Reset
REQ-030 rst SHALL force IDLE, counter 0, read_data 0, sram_addr 0, sram_we_n 1, sram_dq_oe 0 and sram_dq_out 0, immediately and independent of clk.
REQ-031 Reset mid-access SHALL abort the access; a partial write SHALL not be retried.
REQ-032 After reset release, ready SHALL be 1 while no request is present.

Structure
REQ-033 The state encoding and DATA_BASE default SHALL live in the shared arm_pkg package.
REQ-034 The wait counter SHALL be one sub-module, wait_counter (clear, enable, terminal-count output).
REQ-035 There SHALL be no inout port; the top level instantiates the DQ tristate.

Verification
REQ-036 Reset mid-HI of a write -> next cycle shows IDLE, sram_we_n=1, sram_dq_oe=0 and ready=1 with no request.
REQ-037 WAIT_CYCLES=2, write address 1028 data 32'hDEADBEEF -> sram_addr 2 for 2 cycles with dq 16'hBEEF, then 3 for 2 cycles with dq 16'hDEAD, ready high in cycle 5.
REQ-038 Read address 1028 with the SRAM model returning 16'hBEEF/16'hDEAD -> read_data=32'hDEADBEEF at ready, held through a later write.
REQ-039 rd_en and wr_en both high -> write performed, read_data unchanged.
REQ-040 Back-to-back requests with WAIT_CYCLES=1 -> ready pulses every 4 cycles with no IDLE gap; address 1020 -> index wraps to 17'h1FFFF.
